// File: rtl/sb_pkg.sv
// Shared sideband definitions: symbol bytes, transaction types, parser/deserializer states, CRC helper.
package sb_pkg;

    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned CRC_W    = 16;
    localparam int unsigned TYPE_W   = 3;
    localparam int unsigned RD_W     = 24;
    localparam int unsigned BITCNT_W = 4;

    localparam logic [BYTE_W-1:0] SB_DLE     = 8'hFE;
    localparam logic [BYTE_W-1:0] SB_STX_CMD = 8'h05;
    localparam logic [BYTE_W-1:0] SB_STX_RSP = 8'h04;
    localparam logic [BYTE_W-1:0] SB_LSE     = 8'h80;
    localparam logic [BYTE_W-1:0] SB_CLSE    = 8'h7F;
    localparam logic [BYTE_W-1:0] SB_ETX     = 8'h40;

    localparam logic [TYPE_W-1:0] TT_AT_CMD = 3'd2;
    localparam logic [TYPE_W-1:0] TT_AT_RSP = 3'd3;
    localparam logic [TYPE_W-1:0] TT_LT     = 3'd4;

    localparam logic [CRC_W-1:0] CRC_POLY = 16'h8005;
    localparam logic [CRC_W-1:0] CRC_SEED = 16'hFFFF;

    typedef enum logic {
        DS_HUNT,
        DS_SHIFT
    } deser_state_e;

    typedef enum logic [3:0] {
        P_WAIT_DLE,
        P_GOT_DLE,
        P_LT_CLSE,
        P_CMD_ADDR,
        P_CMD_LEN,
        P_RSP_ADDR,
        P_RSP_LEN,
        P_RSP_DATA,
        P_CRC_HI,
        P_CRC_LO,
        P_END_DLE,
        P_END_ETX
    } parse_state_e;

    // Non-reflected CRC-16 (poly 0x8005), one byte folded in MSB first.
    function automatic logic [CRC_W-1:0] crc16_update(input logic [CRC_W-1:0] crc,
                                                      input logic [BYTE_W-1:0] data);
        logic [CRC_W-1:0] c;
        c = crc ^ {data, 8'h00};
        for (int i = 0; i < 8; i++) begin
            if (c[CRC_W-1]) c = (c << 1) ^ CRC_POLY;
            else            c = c << 1;
        end
        return c;
    endfunction

endpackage

// File: rtl/sb_rx_crc16.sv
// Byte-wide CRC-16 accumulator: init loads the seed (folding the byte in when en is also high).
module sb_rx_crc16
    import sb_pkg::*;
(
    input  logic              sb_clk,
    input  logic              rst,
    input  logic              init_i,
    input  logic              en_i,
    input  logic [BYTE_W-1:0] data_i,
    output logic [CRC_W-1:0]  crc_o
);

    logic [CRC_W-1:0] crc_q;

    // CRC register: seed on init, one byte per enabled cycle.
    always_ff @(posedge sb_clk or negedge rst) begin
        if (!rst) begin
            crc_q <= '0;
        end else if (init_i) begin
            crc_q <= en_i ? crc16_update(CRC_SEED, data_i) : CRC_SEED;
        end else if (en_i) begin
            crc_q <= crc16_update(crc_q, data_i);
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/sb_trans_receiver_fsm.sv
// Sideband receiver: 10-bit symbol deserializer feeding a DLE-framed transaction parser.
module sb_trans_receiver_fsm
    import sb_pkg::*;
#(
    parameter int unsigned DATA_BYTES = 3
) (
    input  logic              sb_clk,
    input  logic              rst,
    input  logic              sbrx,
    output logic              trans_valid,
    output logic [TYPE_W-1:0] trans_type,
    output logic [7:0]        at_addr,
    output logic [6:0]        at_len,
    output logic              at_rw,
    output logic [RD_W-1:0]   rd_data,
    output logic              crc_err,
    output logic              frame_err
);

    localparam logic [1:0] LAST_BYTE = 2'(DATA_BYTES - 1);

    deser_state_e          ds_q;
    logic [BITCNT_W-1:0]   bit_cnt_q;
    logic [BYTE_W-1:0]     shift_q;

    parse_state_e          ps_q;
    logic                  is_rsp_q;
    logic [1:0]            byte_cnt_q;
    logic [7:0]            addr_q;
    logic [6:0]            len_q;
    logic                  rw_q;
    logic [RD_W-1:0]       data_q;
    logic [CRC_W-1:0]      rx_crc_q;
    logic [CRC_W-1:0]      calc_crc;

    logic                  stop_slot_c;
    logic                  sym_valid_c;
    logic                  stop_err_c;
    logic [BYTE_W-1:0]     sym_byte_c;
    logic                  crc_init_c;
    logic                  crc_en_c;

    // The stop bit is judged on the edge that samples it so the parser reacts on that same edge.
    assign stop_slot_c = (ds_q == DS_SHIFT) && (bit_cnt_q == 4'd9);
    assign sym_valid_c = stop_slot_c && sbrx;
    assign stop_err_c  = stop_slot_c && !sbrx;
    assign sym_byte_c  = shift_q;

    // Deserializer: hunt for a start bit, then shift data bits LSB first and release at the stop slot.
    always_ff @(posedge sb_clk or negedge rst) begin
        if (!rst) begin
            ds_q      <= DS_HUNT;
            bit_cnt_q <= '0;
            shift_q   <= '0;
        end else begin
            case (ds_q)
                DS_HUNT: begin
                    if (!sbrx) begin
                        ds_q      <= DS_SHIFT;
                        bit_cnt_q <= 4'd1;
                    end
                end
                DS_SHIFT: begin
                    if (bit_cnt_q == 4'd9) begin
                        ds_q      <= DS_HUNT;
                        bit_cnt_q <= '0;
                    end else begin
                        shift_q   <= {sbrx, shift_q[BYTE_W-1:1]};
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                    end
                end
                default: begin
                    ds_q      <= DS_HUNT;
                    bit_cnt_q <= '0;
                end
            endcase
        end
    end

    // CRC covers STX through the last payload byte.
    assign crc_init_c = sym_valid_c && (ps_q == P_GOT_DLE) &&
                        ((sym_byte_c == SB_STX_CMD) || (sym_byte_c == SB_STX_RSP));
    assign crc_en_c   = crc_init_c ||
                        (sym_valid_c && (ps_q inside {P_CMD_ADDR, P_CMD_LEN, P_RSP_ADDR,
                                                      P_RSP_LEN, P_RSP_DATA}));

    sb_rx_crc16 u_crc (
        .sb_clk (sb_clk),
        .rst    (rst),
        .init_i (crc_init_c),
        .en_i   (crc_en_c),
        .data_i (sym_byte_c),
        .crc_o  (calc_crc)
    );

    // Frame parser with registered status pulses; published fields change only on a good frame.
    always_ff @(posedge sb_clk or negedge rst) begin
        if (!rst) begin
            ps_q        <= P_WAIT_DLE;
            is_rsp_q    <= 1'b0;
            byte_cnt_q  <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            rw_q        <= 1'b0;
            data_q      <= '0;
            rx_crc_q    <= '0;
            trans_valid <= 1'b0;
            trans_type  <= '0;
            at_addr     <= '0;
            at_len      <= '0;
            at_rw       <= 1'b0;
            rd_data     <= '0;
            crc_err     <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            trans_valid <= 1'b0;
            crc_err     <= 1'b0;
            frame_err   <= 1'b0;
            if (stop_err_c) begin
                frame_err <= 1'b1;
                ps_q      <= P_WAIT_DLE;
            end else if (sym_valid_c) begin
                case (ps_q)
                    P_WAIT_DLE: begin
                        if (sym_byte_c == SB_DLE) ps_q <= P_GOT_DLE;
                    end
                    P_GOT_DLE: begin
                        if (sym_byte_c == SB_STX_CMD) begin
                            ps_q       <= P_CMD_ADDR;
                            is_rsp_q   <= 1'b0;
                            byte_cnt_q <= '0;
                        end else if (sym_byte_c == SB_STX_RSP) begin
                            ps_q       <= P_RSP_ADDR;
                            is_rsp_q   <= 1'b1;
                            byte_cnt_q <= '0;
                        end else if (sym_byte_c == SB_LSE) begin
                            ps_q <= P_LT_CLSE;
                        end else if (sym_byte_c != SB_DLE) begin
                            frame_err <= 1'b1;
                            ps_q      <= P_WAIT_DLE;
                        end
                    end
                    P_LT_CLSE: begin
                        if (sym_byte_c == SB_CLSE) begin
                            trans_valid <= 1'b1;
                            trans_type  <= TT_LT;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        ps_q <= P_WAIT_DLE;
                    end
                    P_CMD_ADDR, P_RSP_ADDR: begin
                        addr_q <= sym_byte_c;
                        ps_q   <= (ps_q == P_CMD_ADDR) ? P_CMD_LEN : P_RSP_LEN;
                    end
                    P_CMD_LEN, P_RSP_LEN: begin
                        len_q <= sym_byte_c[7:1];
                        rw_q  <= sym_byte_c[0];
                        ps_q  <= (ps_q == P_CMD_LEN) ? P_CRC_HI : P_RSP_DATA;
                    end
                    P_RSP_DATA: begin
                        data_q     <= {data_q[RD_W-BYTE_W-1:0], sym_byte_c};
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == LAST_BYTE) ps_q <= P_CRC_HI;
                    end
                    P_CRC_HI: begin
                        rx_crc_q[15:8] <= sym_byte_c;
                        ps_q           <= P_CRC_LO;
                    end
                    P_CRC_LO: begin
                        rx_crc_q[7:0] <= sym_byte_c;
                        ps_q          <= P_END_DLE;
                    end
                    P_END_DLE: begin
                        if (sym_byte_c == SB_DLE) begin
                            ps_q <= P_END_ETX;
                        end else begin
                            frame_err <= 1'b1;
                            ps_q      <= P_WAIT_DLE;
                        end
                    end
                    P_END_ETX: begin
                        if (sym_byte_c != SB_ETX) begin
                            frame_err <= 1'b1;
                        end else if (calc_crc == rx_crc_q) begin
                            trans_valid <= 1'b1;
                            trans_type  <= is_rsp_q ? TT_AT_RSP : TT_AT_CMD;
                            at_addr     <= addr_q;
                            at_len      <= len_q;
                            at_rw       <= rw_q;
                            if (is_rsp_q) rd_data <= data_q;
                        end else begin
                            crc_err <= 1'b1;
                        end
                        ps_q <= P_WAIT_DLE;
                    end
                    default: ps_q <= P_WAIT_DLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sb_trans_receiver_fsm.sv
// Directed and randomized frames against a frame-level reference model of the sideband receiver.
module tb_sb_trans_receiver_fsm;

    logic        sb_clk = 1'b0;
    logic        rst    = 1'b0;
    logic        sbrx   = 1'b1;
    logic        trans_valid;
    logic [2:0]  trans_type;
    logic [7:0]  at_addr;
    logic [6:0]  at_len;
    logic        at_rw;
    logic [23:0] rd_data;
    logic        crc_err;
    logic        frame_err;

    sb_trans_receiver_fsm #(.DATA_BYTES(3)) dut (
        .sb_clk      (sb_clk),
        .rst         (rst),
        .sbrx        (sbrx),
        .trans_valid (trans_valid),
        .trans_type  (trans_type),
        .at_addr     (at_addr),
        .at_len      (at_len),
        .at_rw       (at_rw),
        .rd_data     (rd_data),
        .crc_err     (crc_err),
        .frame_err   (frame_err)
    );

    always #5 sb_clk = ~sb_clk;

    int checks = 0;
    int errors = 0;

    // Pulse totals seen by an independent monitor.
    int tv_total = 0, ce_total = 0, fe_total = 0, overlap_total = 0;
    always @(negedge sb_clk) begin
        if (trans_valid) tv_total++;
        if (crc_err)     ce_total++;
        if (frame_err)   fe_total++;
        if (32'(trans_valid) + 32'(crc_err) + 32'(frame_err) > 1) overlap_total++;
    end

    // Reference model state.
    logic [2:0]  m_type = '0;
    logic [7:0]  m_addr = '0;
    logic [6:0]  m_len  = '0;
    logic        m_rw   = 1'b0;
    logic [23:0] m_data = '0;
    int m_tv = 0, m_ce = 0, m_fe = 0;

    logic [7:0] fq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bit-serial LFSR form of CRC-16/0x8005, init 0xFFFF, message MSB first.
    function automatic logic [15:0] ref_crc(input logic [7:0] msg[$]);
        logic [15:0] r;
        logic        fb;
        r = 16'hFFFF;
        foreach (msg[k]) begin
            for (int j = 7; j >= 0; j--) begin
                fb = r[15] ^ msg[k][j];
                r  = {r[14:0], 1'b0};
                if (fb) r = r ^ 16'h8005;
            end
        end
        return r;
    endfunction

    // One 10-bit symbol; returns #1 after the edge that samples the stop bit.
    task automatic send_sym(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            sbrx = bits[i];
            @(posedge sb_clk);
            #1;
        end
    endtask

    // Sends fq back to back; outcome on the last symbol: 0 none, 1 valid, 2 crc_err, 3 frame_err.
    task automatic run_frame(input int outcome, input int stop_err_idx);
        int ev;
        bit bad;
        for (int i = 0; i < fq.size(); i++) begin
            bad = (i == stop_err_idx);
            send_sym(fq[i], !bad);
            ev = bad ? 3 : ((i == fq.size() - 1) ? outcome : 0);
            chk("sym_trans_valid", 32'(trans_valid), 32'(ev == 1));
            chk("sym_crc_err",     32'(crc_err),     32'(ev == 2));
            chk("sym_frame_err",   32'(frame_err),   32'(ev == 3));
            if (ev == 1) m_tv++;
            if (ev == 2) m_ce++;
            if (ev == 3) m_fe++;
            if (bad) break;
        end
        sbrx = 1'b1;
    endtask

    task automatic check_fields(input string tag);
        chk({tag, "_type"}, 32'(trans_type), 32'(m_type));
        chk({tag, "_addr"}, 32'(at_addr),    32'(m_addr));
        chk({tag, "_len"},  32'(at_len),     32'(m_len));
        chk({tag, "_rw"},   32'(at_rw),      32'(m_rw));
        chk({tag, "_data"}, 32'(rd_data),    32'(m_data));
    endtask

    task automatic build_lt(input logic [7:0] clse);
        fq = {};
        fq.push_back(8'hFE);
        fq.push_back(8'h80);
        fq.push_back(clse);
    endtask

    task automatic build_at(input bit rsp, input logic [7:0] addr, input logic [7:0] lenb,
                            input logic [23:0] data, input bit flip, input logic [7:0] etx);
        logic [7:0]  body[$];
        logic [15:0] c;
        body = {};
        body.push_back(rsp ? 8'h04 : 8'h05);
        body.push_back(addr);
        body.push_back(lenb);
        if (rsp) begin
            body.push_back(data[23:16]);
            body.push_back(data[15:8]);
            body.push_back(data[7:0]);
        end
        c = ref_crc(body);
        if (flip) c[0] = ~c[0];
        fq = {};
        fq.push_back(8'hFE);
        foreach (body[k]) fq.push_back(body[k]);
        fq.push_back(c[15:8]);
        fq.push_back(c[7:0]);
        fq.push_back(8'hFE);
        fq.push_back(etx);
    endtask

    initial begin
        int          kind, corrupt, nj;
        logic [7:0]  addr, lenb, b;
        logic [23:0] data;

        // Reset state.
        repeat (3) @(posedge sb_clk);
        #1;
        chk("rst_valid", 32'(trans_valid), 0);
        chk("rst_crc_err", 32'(crc_err), 0);
        chk("rst_frame_err", 32'(frame_err), 0);
        check_fields("rst");
        @(negedge sb_clk);
        rst = 1'b1;

        // Idle line, spurious bytes, then an LT frame.
        repeat (20) @(posedge sb_clk);
        #1;
        chk("idle_pulses", 32'(tv_total + ce_total + fe_total), 0);
        fq = {8'h11, 8'h40};
        run_frame(0, -1);
        build_lt(8'h7F);
        run_frame(1, -1);
        m_type = 3'd4;
        check_fields("lt");

        // Repeated DLE before LSE.
        fq = {8'hFE, 8'hFE, 8'h80, 8'h7F};
        run_frame(1, -1);
        check_fields("lt_dle_dle");

        // AT command.
        build_at(1'b0, 8'h4E, 8'h04, 24'h0, 1'b0, 8'h40);
        run_frame(1, -1);
        m_type = 3'd2; m_addr = 8'h4E; m_len = 7'd2; m_rw = 1'b0;
        check_fields("cmd");

        // AT response.
        build_at(1'b1, 8'h4E, 8'h0A, 24'h123456, 1'b0, 8'h40);
        run_frame(1, -1);
        m_type = 3'd3; m_len = 7'd5; m_data = 24'h123456;
        check_fields("rsp");

        // Response with corrupted CRC: fields hold.
        build_at(1'b1, 8'h33, 8'hFF, 24'hABCDEF, 1'b1, 8'h40);
        run_frame(2, -1);
        check_fields("rsp_crc_bad");

        // Stop error on the address symbol, then a good LT frame.
        build_at(1'b0, 8'h4E, 8'h04, 24'h0, 1'b0, 8'h40);
        run_frame(0, 2);
        build_lt(8'h7F);
        run_frame(1, -1);
        m_type = 3'd4;
        check_fields("stop_err_then_lt");

        // Reset after the third payload byte, then a full command.
        build_at(1'b1, 8'h21, 8'h0A, 24'hC0FFEE, 1'b0, 8'h40);
        fq = fq[0:6];
        run_frame(0, -1);
        @(negedge sb_clk);
        rst = 1'b0;
        #1;
        m_type = '0; m_addr = '0; m_len = '0; m_rw = 1'b0; m_data = '0;
        chk("midrst_valid", 32'(trans_valid), 0);
        check_fields("midrst");
        repeat (3) @(posedge sb_clk);
        @(negedge sb_clk);
        rst = 1'b1;
        build_at(1'b0, 8'h5A, 8'h07, 24'h0, 1'b0, 8'h40);
        run_frame(1, -1);
        m_type = 3'd2; m_addr = 8'h5A; m_len = 7'd3; m_rw = 1'b1;
        check_fields("after_rst_cmd");

        // Randomized frames with random corruption.
        for (int n = 0; n < 40; n++) begin
            nj = $urandom_range(0, 2);
            for (int j = 0; j < nj; j++) begin
                fq = {8'($urandom_range(0, 253))};
                run_frame(0, -1);
            end
            kind    = $urandom_range(0, 2);
            corrupt = $urandom_range(0, 6);
            addr    = 8'($urandom);
            lenb    = 8'($urandom);
            data    = 24'($urandom);
            do b = 8'($urandom); while (b == 8'h40 || b == 8'h7F);
            if (kind == 0) begin
                build_lt((corrupt == 4) ? b : 8'h7F);
            end else begin
                build_at(kind == 2, addr, lenb, data, corrupt == 3, (corrupt == 4) ? b : 8'h40);
            end
            if (corrupt == 5) begin
                run_frame(0, $urandom_range(0, fq.size() - 1));
            end else if (corrupt == 6) begin
                do b = 8'($urandom);
                while (b == 8'h04 || b == 8'h05 || b == 8'h80 || b == 8'hFE);
                fq = {8'hFE, b};
                run_frame(3, -1);
            end else if (corrupt == 4) begin
                run_frame(3, -1);
            end else if (corrupt == 3 && kind != 0) begin
                run_frame(2, -1);
            end else begin
                run_frame(1, -1);
                if (kind == 0) begin
                    m_type = 3'd4;
                end else begin
                    m_type = (kind == 2) ? 3'd3 : 3'd2;
                    m_addr = addr;
                    m_len  = lenb[7:1];
                    m_rw   = lenb[0];
                    if (kind == 2) m_data = data;
                end
            end
            check_fields("rand");
        end

        // Pulse totals and exclusivity over the whole run.
        repeat (4) @(posedge sb_clk);
        #1;
        chk("total_valid", 32'(tv_total), 32'(m_tv));
        chk("total_crc_err", 32'(ce_total), 32'(m_ce));
        chk("total_frame_err", 32'(fe_total), 32'(m_fe));
        chk("pulse_overlap", 32'(overlap_total), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
